// File: rtl/flap_input_arbiter.sv
// -----------------------------------------------------------------------------
// flap_input_arbiter
//
// Front end for the player flap buttons. Each raw key is synchronised,
// debounced and rising-edge detected; every accepted press becomes a pending
// request. Pending requests are granted round-robin as one-cycle flap pulses,
// with an enforced cooldown between consecutive flaps.
//
// Ports
//   Clock     system clock, all logic on the rising edge
//   Reset     asynchronous, active-high; clears all state
//   key       raw active-high buttons, asynchronous to Clock
//   enable    game running; 0 clears pending requests and suppresses grants
//   flap      one-cycle pulse per granted press
//   flap_src  index of the key served; holds its last value when flap=0
//   pending   registered pending-request bits
//   busy      high while the arbiter is granting or cooling down
//   dropped   saturating count of presses merged into an already-pending bit
// -----------------------------------------------------------------------------
module flap_input_arbiter #(
    parameter int unsigned N_KEYS          = 2,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned COOLDOWN_CYCLES = 8,
    localparam int unsigned SRC_W          = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [N_KEYS-1:0] key,
    input  logic              enable,
    output logic              flap,
    output logic [SRC_W-1:0]  flap_src,
    output logic [N_KEYS-1:0] pending,
    output logic              busy,
    output logic [7:0]        dropped
);

    localparam int unsigned DC_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned CD_W = $clog2(COOLDOWN_CYCLES + 1);
    localparam logic [DC_W-1:0] DC_MAX = DC_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StCooldown
    } state_e;

    // ---------------------------------------------------------------------
    // Input conditioning: synchroniser, debouncer, edge detector
    // ---------------------------------------------------------------------
    logic [N_KEYS-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [N_KEYS-1:0][DC_W-1:0]        dc_q, dc_d;
    logic [N_KEYS-1:0]                  sync_s;
    logic [N_KEYS-1:0]                  deb_q, deb_d;
    logic [N_KEYS-1:0]                  deb_prev_q, deb_prev_d;
    logic [N_KEYS-1:0]                  rise;

    always_comb begin
        for (int i = 0; i < N_KEYS; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], key[i]};
            sync_s[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    // The counter restarts whenever the synchronised level agrees with the
    // accepted level, so only a run of DEBOUNCE_CYCLES disagreeing samples
    // flips the debounced output.
    always_comb begin
        for (int i = 0; i < N_KEYS; i++) begin
            dc_d[i]  = '0;
            deb_d[i] = deb_q[i];
            if (sync_s[i] != deb_q[i]) begin
                if (dc_q[i] == DC_MAX) begin
                    deb_d[i] = sync_s[i];
                end else begin
                    dc_d[i] = dc_q[i] + DC_W'(1);
                end
            end
        end
    end

    assign deb_prev_d = deb_q;
    assign rise       = deb_q & ~deb_prev_q;

    // ---------------------------------------------------------------------
    // Arbiter state
    // ---------------------------------------------------------------------
    state_e              state_q, state_d;
    logic [SRC_W-1:0]    grant_q, grant_d;
    logic [SRC_W-1:0]    last_grant_q, last_grant_d;
    logic [CD_W-1:0]     cd_q, cd_d;
    logic [N_KEYS-1:0]   pending_q, pending_d;
    logic [7:0]          dropped_q, dropped_d;

    // Round-robin pick: rotate the pending vector so that bit 0 corresponds
    // to last_grant+1, take the lowest set bit, then map it back.
    logic [2*N_KEYS-1:0] pend2;
    logic [SRC_W:0]      shamt;
    logic [N_KEYS-1:0]   rot;
    int                  sel_off;
    logic [SRC_W-1:0]    sel_idx;

    always_comb begin
        pend2   = {pending_q, pending_q};
        shamt   = {1'b0, last_grant_q} + (SRC_W + 1)'(1);
        rot     = N_KEYS'(pend2 >> shamt);
        sel_off = 0;
        for (int j = N_KEYS - 1; j >= 0; j--) begin
            if (rot[j]) begin
                sel_off = j;
            end
        end
        sel_idx = SRC_W'((int'(last_grant_q) + 1 + sel_off) % int'(N_KEYS));
    end

    // ---------------------------------------------------------------------
    // Pending capture and drop counting
    // ---------------------------------------------------------------------
    logic [N_KEYS-1:0] clr;
    logic              drop_any;

    always_comb begin
        clr = '0;
        for (int j = 0; j < N_KEYS; j++) begin
            clr[j] = (state_q == StGrant) && enable && (grant_q == SRC_W'(j));
        end
    end

    always_comb begin
        drop_any  = 1'b0;
        pending_d = pending_q;
        for (int j = 0; j < N_KEYS; j++) begin
            if (!enable) begin
                pending_d[j] = 1'b0;
            end else if (clr[j]) begin
                // A press landing on the clearing edge re-arms the bit.
                pending_d[j] = rise[j];
            end else if (rise[j]) begin
                if (pending_q[j]) begin
                    drop_any = 1'b1;
                end
                pending_d[j] = 1'b1;
            end
        end
        dropped_d = dropped_q;
        if (drop_any && (dropped_q != 8'hFF)) begin
            dropped_d = dropped_q + 8'd1;
        end
    end

    // ---------------------------------------------------------------------
    // Grant / cooldown sequencing
    // ---------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cd_d         = cd_q;
        if (!enable) begin
            state_d = StIdle;
            cd_d    = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (|pending_q) begin
                        state_d = StGrant;
                        grant_d = sel_idx;
                    end
                end
                StGrant: begin
                    state_d      = StCooldown;
                    last_grant_d = grant_q;
                    cd_d         = CD_W'(COOLDOWN_CYCLES);
                end
                StCooldown: begin
                    if (cd_q == CD_W'(1)) begin
                        state_d = StIdle;
                    end else begin
                        cd_d = cd_q - CD_W'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync_q       <= '0;
            dc_q         <= '0;
            deb_q        <= '0;
            deb_prev_q   <= '0;
            pending_q    <= '0;
            dropped_q    <= '0;
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= SRC_W'(N_KEYS - 1);
            cd_q         <= '0;
        end else begin
            sync_q       <= sync_d;
            dc_q         <= dc_d;
            deb_q        <= deb_d;
            deb_prev_q   <= deb_prev_d;
            pending_q    <= pending_d;
            dropped_q    <= dropped_d;
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cd_q         <= cd_d;
        end
    end

    // flap is gated by enable so that disabling the game kills a pulse at once.
    assign flap     = (state_q == StGrant) && enable;
    assign flap_src = grant_q;
    assign busy     = (state_q != StIdle);
    assign pending  = pending_q;
    assign dropped  = dropped_q;

endmodule
